apa102_out: RTL and testbench

//  APA102 SPI frame transmitter: serialises NUM_LEDS 24-bit colour words into one
//  APA102 frame (start frame, per-LED words with global brightness, end frame) on sck/sda.

---
 rtl/apa102_out_pkg.sv | 25 ++
 rtl/apa102_bit_tick.sv | 43 ++++
 rtl/apa102_out.sv | 155 +++++++++++++++
 tb/tb_apa102_out.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/apa102_out_pkg.sv
// Shared APA102 framing constants and state encoding, common to the transmitter
// and the loopback receiver.
package apa102_out_pkg;

  localparam int START_BITS  = 32;
  localparam int WORD_BITS   = 32;
  localparam int COLOUR_BITS = 24;
  localparam int HDR_BITS    = 8;
  localparam logic [2:0] LED_HDR = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START_FR,
    ST_LED,
    ST_END_FR
  } state_e;

  // Bit idx (0 = first sent) of the 8-bit LED header {111, brightness}.
  function automatic logic hdr_bit(input logic [4:0] bright, input logic [2:0] idx);
    logic [7:0] hdr;
    hdr = {LED_HDR, bright};
    return hdr[3'd7 - idx];
  endfunction

endpackage

// File: rtl/apa102_bit_tick.sv
// sck phase timer: CLK_DIV clk cycles per phase, reporting the edge that ends the
// low phase (rise_tick) and the edge that ends the high phase (fall_tick).
module apa102_bit_tick #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  output logic rise_tick_o,
  output logic fall_tick_o
);

  localparam int CW = $clog2(CLK_DIV) + 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          high_q, high_d;
  logic          wrap;

  always_comb begin
    wrap   = (cnt_q == LAST);
    cnt_d  = wrap ? '0 : cnt_q + 1'b1;
    high_d = high_q ^ wrap;
    if (!en_i) begin
      cnt_d  = '0;
      high_d = 1'b0;
    end
  end

  assign rise_tick_o = en_i && wrap && !high_q;
  assign fall_tick_o = en_i && wrap && high_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      high_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      high_q <= high_d;
    end
  end

endmodule

// File: rtl/apa102_out.sv
// APA102 frame transmitter: start frame, NUM_LEDS brightness+colour words, all-ones
// end frame. sda only moves on the edge that drops sck.
module apa102_out
  import apa102_out_pkg::*;
#(
  parameter int NUM_LEDS = 7,
  parameter int CLK_DIV  = 4,
  parameter int END_BITS = 32
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            start_i,
  input  logic [4:0]                      brightness_i,
  input  logic [NUM_LEDS*COLOUR_BITS-1:0] data_in_i,
  output logic                            busy_o,
  output logic                            done_o,
  output logic                            sck_o,
  output logic                            sda_o
);

  localparam int DW  = NUM_LEDS * COLOUR_BITS;
  localparam int WCW = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
  localparam int ECW = (END_BITS > 1) ? $clog2(END_BITS) : 1;
  localparam logic [WCW-1:0] LAST_WORD = WCW'(NUM_LEDS - 1);
  localparam logic [ECW-1:0] LAST_END  = ECW'(END_BITS - 1);
  localparam logic [4:0]     LAST_BIT  = 5'(WORD_BITS - 1);
  localparam logic [4:0]     HDR_LEN   = 5'(HDR_BITS);

  state_e         state_q, state_d;
  logic [DW-1:0]  shadow_q, shadow_d;
  logic [4:0]     bright_q, bright_d;
  logic [4:0]     bit_q, bit_d, nxt_bit;
  logic [WCW-1:0] word_q, word_d;
  logic [ECW-1:0] end_q, end_d;
  logic           sck_q, sck_d, sda_q, sda_d, busy_q, busy_d, done_q, done_d;
  logic           tick_en, rise_tick, fall_tick;

  assign tick_en = (state_q != ST_IDLE);

  apa102_bit_tick #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk         (clk),
    .rst_n       (rst_n),
    .en_i        (tick_en),
    .rise_tick_o (rise_tick),
    .fall_tick_o (fall_tick)
  );

  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    bright_d = bright_q;
    bit_d    = bit_q;
    word_d   = word_q;
    end_d    = end_q;
    sck_d    = sck_q;
    sda_d    = sda_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    nxt_bit  = bit_q + 5'd1;
    if (state_q == ST_IDLE) begin
      if (start_i && !busy_q) begin
        state_d  = ST_START_FR;
        shadow_d = data_in_i;
        bright_d = brightness_i;
        busy_d   = 1'b1;
        bit_d    = '0;
        word_d   = '0;
        end_d    = '0;
        sck_d    = 1'b0;
        sda_d    = 1'b0;
      end
    end else begin
      if (rise_tick) sck_d = 1'b1;
      if (fall_tick) begin
        sck_d = 1'b0;
        case (state_q)
          ST_START_FR: begin
            if (bit_q == LAST_BIT) begin
              state_d = ST_LED;
              bit_d   = '0;
              word_d  = '0;
              sda_d   = 1'b1;
            end else begin
              bit_d = nxt_bit;
              sda_d = 1'b0;
            end
          end
          ST_LED: begin
            // Shadow MSB always holds the colour bit currently on the wire.
            if (bit_q >= HDR_LEN) shadow_d = shadow_q << 1;
            if (bit_q == LAST_BIT) begin
              bit_d = '0;
              sda_d = 1'b1;
              if (word_q == LAST_WORD) begin
                state_d = ST_END_FR;
                end_d   = '0;
              end else begin
                word_d = word_q + 1'b1;
              end
            end else begin
              bit_d = nxt_bit;
              if (nxt_bit < HDR_LEN)       sda_d = hdr_bit(bright_q, nxt_bit[2:0]);
              else if (nxt_bit == HDR_LEN) sda_d = shadow_q[DW-1];
              else                         sda_d = shadow_q[DW-2];
            end
          end
          ST_END_FR: begin
            if (end_q == LAST_END) begin
              state_d = ST_IDLE;
              sda_d   = 1'b0;
              busy_d  = 1'b0;
              done_d  = 1'b1;
            end else begin
              end_d = end_q + 1'b1;
              sda_d = 1'b1;
            end
          end
          default: state_d = ST_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      shadow_q <= '0;
      bright_q <= '0;
      bit_q    <= '0;
      word_q   <= '0;
      end_q    <= '0;
      sck_q    <= 1'b0;
      sda_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      bright_q <= bright_d;
      bit_q    <= bit_d;
      word_q   <= word_d;
      end_q    <= end_d;
      sck_q    <= sck_d;
      sda_q    <= sda_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign sck_o  = sck_q;
  assign sda_o  = sda_q;

endmodule

// File: tb/tb_apa102_out.sv
// Bench for apa102_out: three parameter sets driven in parallel, each checked every
// cycle against a cycle-index model; the main set is also decoded as a receiver.
module tb_apa102_out;

  localparam int N0   = 7;
  localparam int D0   = 2;
  localparam int E0   = 32;
  localparam int TOT0 = 32 * (1 + N0) + E0;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [4:0]   br    = '0;
  logic [167:0] data  = '0;

  logic [2:0] sck_v, sda_v, busy_v, done_v;
  logic [2:0] e_sck_v, e_sda_v, e_busy_v, e_done_v;

  int   checks   = 0;
  int   failures = 0;
  bit   rx0[$];
  bit   prev_sck0 = 1'b0;
  int   n_done0   = 0;
  logic [167:0] cap_data = '0;
  logic [4:0]   cap_br   = '0;
  bit   lit1 = 1'b0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : cfg
    localparam int D   = (g == 0) ? D0 : (g == 1) ? 1 : 4;
    localparam int N   = (g == 0) ? N0 : (g == 1) ? 2 : 1;
    localparam int E   = (g == 0) ? E0 : (g == 1) ? 1 : 3;
    localparam int TOT = 32 * (1 + N) + E;

    logic sck, sda, busy, done;
    logic e_sck, e_sda, e_busy, e_done;

    apa102_out #(.NUM_LEDS(N), .CLK_DIV(D), .END_BITS(E)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start_i      (start),
      .brightness_i (br),
      .data_in_i    (data[N*24-1:0]),
      .busy_o       (busy),
      .done_o       (done),
      .sck_o        (sck),
      .sda_o        (sda)
    );

    assign sck_v[g]    = sck;
    assign sda_v[g]    = sda;
    assign busy_v[g]   = busy;
    assign done_v[g]   = done;
    assign e_sck_v[g]  = e_sck;
    assign e_sda_v[g]  = e_sda;
    assign e_busy_v[g] = e_busy;
    assign e_done_v[g] = e_done;

    // m_k counts clk cycles since the accepting edge; the frame is the list of bits.
    bit m_act  = 1'b0;
    bit m_done = 1'b0;
    int m_k    = 0;
    bit m_bits[TOT];

    always @(posedge clk) begin
      int w, j;
      m_done = 1'b0;
      if (!rst_n) begin
        m_act = 1'b0;
      end else if (m_act) begin
        m_k++;
        if (m_k > 2 * D * TOT) begin
          m_act  = 1'b0;
          m_done = 1'b1;
        end
      end else if (start) begin
        m_act = 1'b1;
        m_k   = 1;
        for (int i = 0; i < TOT; i++) begin
          if (i < 32) m_bits[i] = 1'b0;
          else if (i >= 32 * (1 + N)) m_bits[i] = 1'b1;
          else begin
            w = (i - 32) / 32;
            j = (i - 32) % 32;
            if (j < 3)      m_bits[i] = 1'b1;
            else if (j < 8) m_bits[i] = br[7-j];
            else            m_bits[i] = data[(N - w) * 24 - 1 - (j - 8)];
          end
        end
      end
    end

    always_comb begin
      e_sck  = 1'b0;
      e_sda  = 1'b0;
      e_busy = 1'b0;
      e_done = m_done;
      if (m_act) begin
        e_sck  = ((m_k - 1) % (2 * D)) >= D;
        e_sda  = m_bits[(m_k - 1) / (2 * D)];
        e_busy = 1'b1;
        e_done = 1'b0;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  function automatic logic [31:0] rxw(input int base);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) r = {r[30:0], rx0[base+i]};
    return r;
  endfunction

  task automatic frame_check();
    logic [31:0] w;
    chk("frame_len", 32'(rx0.size()), 32'(TOT0));
    if (rx0.size() == TOT0) begin
      chk("start_frame", rxw(0), 32'h0);
      for (int n = 0; n < N0; n++) begin
        w = rxw(32 + 32 * n);
        chk("led_hdr", 32'(w[31:29]), 32'(3'b111));
        chk("led_bright", 32'(w[28:24]), 32'(cap_br));
        chk("led_colour", 32'(w[23:0]), 32'(cap_data[(N0-n)*24-1 -: 24]));
      end
      chk("end_frame", rxw(TOT0 - 32), 32'hFFFF_FFFF);
      if (lit1) begin
        chk("lit_led0", rxw(32), 32'hFFFF_0000);
        chk("lit_led3", rxw(32 + 3 * 32), 32'hFF12_3456);
        chk("lit_led6", rxw(32 + 6 * 32), 32'hFF80_0000);
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    checks++;
    if ({sck_v, sda_v, busy_v, done_v} !== {e_sck_v, e_sda_v, e_busy_v, e_done_v}) begin
      failures++;
      $display("FAIL cycle_model t=%0t sck=%b req %b sda=%b req %b busy=%b req %b done=%b req %b",
               $time, sck_v, e_sck_v, sda_v, e_sda_v, busy_v, e_busy_v, done_v, e_done_v);
    end
    if (sck_v[0] && !prev_sck0) rx0.push_back(sda_v[0]);
    prev_sck0 = sck_v[0];
    if (done_v[0]) begin
      n_done0++;
      frame_check();
      rx0.delete();
    end
  endtask

  task automatic go();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input string nm, input int budget);
    bit got;
    got = 1'b0;
    for (int i = 0; i < budget && !got; i++) begin
      step();
      got = done_v[0];
    end
    checks++;
    if (!got) begin
      failures++;
      $display("FAIL %s timeout actual=no_done required=done", nm);
    end
  endtask

  initial begin
    logic [191:0] rnd;
    int d0;

    rst_n = 1'b0;
    repeat (3) step();
    chk("rst_sck", 32'(sck_v), 32'h0);
    chk("rst_sda", 32'(sda_v), 32'h0);
    chk("rst_busy", 32'(busy_v), 32'h0);
    chk("rst_done", 32'(done_v), 32'h0);
    rst_n = 1'b1;
    repeat (2) step();

    // Reference frame with hand-computed words.
    data = 168'hFF0000_00FF00_0000FF_123456_ABCDEF_000001_800000;
    br   = 5'h1F;
    cap_data = data; cap_br = br; lit1 = 1'b1;
    go();
    wait_done("t1_done", 1300);
    lit1 = 1'b0;
    chk("t1_done_count", 32'(n_done0), 32'd1);
    repeat (5) step();

    // Starts while busy and inputs churning during the frame are ignored.
    data = 168'h13579B_2468AC_F0F0F0_0F0F0F_55AA55_AA55AA_C3C3C3;
    br   = 5'h0A;
    cap_data = data; cap_br = br;
    d0 = n_done0;
    go();
    start = 1'b1;
    step();
    for (int i = 0; i < 1000; i++) begin
      rnd   = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
      data  = rnd[167:0];
      br    = rnd[172:168];
      start = rnd[180];
      step();
    end
    start = 1'b0;
    wait_done("t34_done", 400);
    chk("t34_done_count", 32'(n_done0 - d0), 32'd1);
    repeat (5) step();

    // Reset mid-frame, then a clean frame.
    data = 168'h010203_040506_070809_0A0B0C_0D0E0F_101112_131415;
    br   = 5'h11;
    cap_data = data; cap_br = br;
    d0 = n_done0;
    go();
    for (int i = 0; i < 1200 && rx0.size() < 100; i++) step();
    chk("t5_reached_bit100", 32'(rx0.size()), 32'd100);
    rst_n = 1'b0;
    step();
    chk("t5_sck", 32'(sck_v[0]), 32'h0);
    chk("t5_sda", 32'(sda_v[0]), 32'h0);
    chk("t5_busy", 32'(busy_v[0]), 32'h0);
    chk("t5_done", 32'(done_v[0]), 32'h0);
    rst_n = 1'b1;
    rx0.delete();
    step();
    chk("t5_no_done", 32'(n_done0 - d0), 32'd0);
    go();
    wait_done("t5_done_after", 1300);
    chk("t5_done_count", 32'(n_done0 - d0), 32'd1);
    repeat (5) step();

    // start held high: back-to-back frames.
    data = 168'hDEADBE_EF0123_456789_FEDCBA_987654_321000_A5A5A5;
    br   = 5'h03;
    cap_data = data; cap_br = br;
    d0 = n_done0;
    start = 1'b1;
    wait_done("t6_frame1", 1300);
    wait_done("t6_frame2", 1300);
    start = 1'b0;
    chk("t6_done_count", 32'(n_done0 - d0), 32'd2);
    step();
    chk("t6_gap_sck", 32'(sck_v[0]), 32'h0);
    repeat (1200) step();
    chk("t6_final_idle", 32'(busy_v), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
